fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_rd_adapter.sv | 102 ++++++++++
 tb/tb_fifo_rd_adapter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the async-FIFO read-side adapter.
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

  // Held entries plus the read whose data has not yet landed.
  function automatic logic [1:0] occ_of(input fifo_state_e s, input logic inflt);
    return 2'(s) + {1'b0, inflt};
  endfunction

endpackage

// File: rtl/fifo_rd_adapter.sv
// Turns the registered-read interface of an async FIFO into a valid/ready
// stream using a head + skid pair, sustaining one word per cycle.
module fifo_rd_adapter
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  input  logic             flush,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       level
);

  fifo_state_e      state_q, state_d;
  logic             inflt_q, inflt_d;
  logic             run_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;
  logic             arrive;
  logic [1:0]       occ;

  assign m_valid = (state_q != EMPTY);
  assign m_data  = head_q;
  assign level   = 2'(state_q);
  assign pop     = m_valid & m_ready;
  assign occ     = occ_of(state_q, inflt_q);

  // run_q holds off reads until the first edge after reset release.
  assign fifo_ren = run_q & ~fifo_empty & ~flush &
                    ((occ < 2'd2) | ((occ == 2'd2) & pop));
  assign inflt_d  = fifo_ren & ~fifo_empty;
  // A read issued the cycle before a flush lands during the flush and is dropped.
  assign arrive   = inflt_q & ~flush;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (arrive) begin
            head_d  = fifo_rdata;
            state_d = ONE;
          end
        end
        ONE: begin
          if (arrive) begin
            if (pop) begin
              head_d = fifo_rdata;
            end else begin
              skid_d  = fifo_rdata;
              state_d = TWO;
            end
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // Arrival without pop cannot occur here: fifo_ren was gated at occ==2.
          if (pop) begin
            head_d = skid_q;
            if (arrive) begin
              skid_d = fifo_rdata;
            end else begin
              state_d = ONE;
            end
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= EMPTY;
      inflt_q <= 1'b0;
      run_q   <= 1'b0;
      head_q  <= '0;
    end else begin
      state_q <= state_d;
      inflt_q <= inflt_d;
      run_q   <= 1'b1;
      head_q  <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench for fifo_rd_adapter with a behavioural registered-read FIFO.
module tb_fifo_rd_adapter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         aresetn = 1'b0;
  logic         fifo_empty;
  logic [W-1:0] fifo_rdata = '0;
  logic         fifo_ren;
  logic         flush = 1'b0;
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_ready = 1'b0;
  logic [1:0]   level;

  logic [W-1:0] src  [0:4095];
  logic [W-1:0] outq [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int out_n  = 0;
  int n_cmp  = 0;
  int n_err  = 0;

  fifo_rd_adapter #(.WIDTH(W)) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren  (fifo_ren),
    .flush     (flush),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read model and stream output monitor.
  always @(posedge clk) begin
    if (fifo_ren && !fifo_empty) begin
      fifo_rdata <= src[rd_ptr];
      rd_ptr     <= rd_ptr + 1;
    end
    if (m_valid && m_ready) begin
      outq[out_n] <= m_data;
      out_n       <= out_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    src[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; flush = 1'b0; m_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", m_valid); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (m_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", m_data); end
    push(8'h5A);
    #1;
    n_cmp++; if (fifo_ren !== 1'b0) begin n_err++; $display("FAIL rst_ren_held: got %b want 0", fifo_ren); end
    tick();
    aresetn = 1'b1;
    #1;
    n_cmp++; if (fifo_ren !== 1'b0) begin n_err++; $display("FAIL rst_ren_release: got %b want 0", fifo_ren); end
    tick();
    n_cmp++; if (fifo_ren !== 1'b1) begin n_err++; $display("FAIL rst_ren_first: got %b want 1", fifo_ren); end
    m_ready = 1'b1;
    repeat (4) tick();
    n_cmp++; if (out_n !== 1) begin n_err++; $display("FAIL rst_out_count: got %0d want 1", out_n); end
    n_cmp++; if (outq[0] !== 8'h5A) begin n_err++; $display("FAIL rst_out_word: got %h want 5a", outq[0]); end
  endtask

  task automatic test_empty();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (fifo_ren !== 1'b0 || m_valid !== 1'b0 || level !== 2'd0) begin
        n_err++;
        $display("FAIL empty_idle[%0d]: got ren=%b valid=%b level=%0d want 0/0/0", i, fifo_ren, m_valid, level);
      end
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_w [3];
    int base;
    exp_w = '{8'h11, 8'h22, 8'h33};
    base = out_n;
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    n_cmp++; if (fifo_ren !== 1'b1) begin n_err++; $display("FAIL stream_ren0: got %b want 1", fifo_ren); end
    tick();
    n_cmp++; if (fifo_ren !== 1'b1 || m_valid !== 1'b0) begin n_err++; $display("FAIL stream_c1: got ren=%b valid=%b want 1/0", fifo_ren, m_valid); end
    tick();
    n_cmp++; if (fifo_ren !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'h11 || level !== 2'd1) begin
      n_err++; $display("FAIL stream_c2: got ren=%b valid=%b data=%h level=%0d want 1/1/11/1", fifo_ren, m_valid, m_data, level); end
    tick();
    n_cmp++; if (fifo_ren !== 1'b0 || m_data !== 8'h22) begin n_err++; $display("FAIL stream_c3: got ren=%b data=%h want 0/22", fifo_ren, m_data); end
    tick();
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h33) begin n_err++; $display("FAIL stream_c4: got valid=%b data=%h want 1/33", m_valid, m_data); end
    tick();
    n_cmp++; if (m_valid !== 1'b0 || level !== 2'd0) begin n_err++; $display("FAIL stream_drained: got valid=%b level=%0d want 0/0", m_valid, level); end
    n_cmp++; if (out_n - base !== 3) begin n_err++; $display("FAIL stream_count: got %0d want 3", out_n - base); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (outq[base+i] !== exp_w[i]) begin n_err++; $display("FAIL stream_order[%0d]: got %h want %h", i, outq[base+i], exp_w[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] exp_w [4];
    int base, rd0;
    exp_w = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    m_ready = 1'b0;
    base = out_n;
    rd0 = rd_ptr;
    for (int i = 0; i < 4; i++) push(exp_w[i]);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (level !== 2'd2 || m_data !== 8'hA1 || fifo_ren !== 1'b0 || rd_ptr - rd0 !== 2) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got level=%0d data=%h ren=%b reads=%0d want 2/a1/0/2", i, level, m_data, fifo_ren, rd_ptr - rd0);
      end
      tick();
    end
    m_ready = 1'b1;
    #1;
    n_cmp++; if (fifo_ren !== 1'b1) begin n_err++; $display("FAIL bp_ren_on_pop: got %b want 1", fifo_ren); end
    repeat (6) tick();
    n_cmp++; if (out_n - base !== 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", out_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (outq[base+i] !== exp_w[i]) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", i, outq[base+i], exp_w[i]); end
    end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL bp_drained: got %0d want 0", level); end
  endtask

  task automatic test_flush();
    logic [W-1:0] exp_w [4];
    int base;
    exp_w = '{8'hB1, 8'hB2, 8'hB4, 8'hB5};
    m_ready = 1'b0;
    base = out_n;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4); push(8'hB5);
    repeat (3) tick();
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL flush_pre_level: got %0d want 2", level); end
    m_ready = 1'b1;
    #1;
    n_cmp++; if (fifo_ren !== 1'b1) begin n_err++; $display("FAIL flush_pre_ren: got %b want 1", fifo_ren); end
    tick();
    flush = 1'b1;
    #1;
    n_cmp++; if (fifo_ren !== 1'b0 || level !== 2'd1 || m_data !== 8'hB2) begin
      n_err++; $display("FAIL flush_cycle: got ren=%b level=%0d data=%h want 0/1/b2", fifo_ren, level, m_data); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || level !== 2'd0) begin n_err++; $display("FAIL flush_after: got valid=%b level=%0d want 0/0", m_valid, level); end
    repeat (6) tick();
    n_cmp++; if (out_n - base !== 4) begin n_err++; $display("FAIL flush_count: got %0d want 4", out_n - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (outq[base+i] !== exp_w[i]) begin n_err++; $display("FAIL flush_order[%0d]: got %h want %h", i, outq[base+i], exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    m_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    repeat (3) tick();
    n_cmp++; if (level !== 2'd2) begin n_err++; $display("FAIL rmid_pre_level: got %0d want 2", level); end
    aresetn = 1'b0;
    #1;
    n_cmp++; if (m_valid !== 1'b0 || level !== 2'd0 || m_data !== 8'h00 || fifo_ren !== 1'b0) begin
      n_err++; $display("FAIL rmid_async: got valid=%b level=%0d data=%h ren=%b want 0/0/00/0", m_valid, level, m_data, fifo_ren); end
    tick(); tick();
    aresetn = 1'b1;
    #1;
    n_cmp++; if (fifo_ren !== 1'b0) begin n_err++; $display("FAIL rmid_ren_release: got %b want 0", fifo_ren); end
    base = out_n;
    m_ready = 1'b1;
    repeat (8) tick();
    n_cmp++; if (out_n - base !== 2) begin n_err++; $display("FAIL rmid_count: got %0d want 2", out_n - base); end
    n_cmp++; if (outq[base] !== 8'hC3 || outq[base+1] !== 8'hC4) begin
      n_err++; $display("FAIL rmid_order: got %h %h want c3 c4", outq[base], outq[base+1]); end
  endtask

  task automatic test_random();
    int base, sb, cyc, lvl_bad, stab_bad, ord_bad;
    logic held_v;
    logic [W-1:0] held_d;
    base = out_n; sb = wr_ptr;
    lvl_bad = 0; stab_bad = 0; ord_bad = 0; cyc = 0;
    held_v = 1'b0; held_d = '0;
    for (int i = 0; i < 1000; i++) push(W'($urandom));
    while ((out_n - base < 1000) && (cyc < 8000)) begin
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (level > 2'd2) lvl_bad++;
      if (held_v && m_valid && m_data !== held_d) stab_bad++;
      held_v = m_valid && !m_ready;
      held_d = m_data;
      tick();
      cyc++;
    end
    n_cmp++; if (out_n - base !== 1000) begin n_err++; $display("FAIL rand_count: got %0d want 1000 (cycles %0d)", out_n - base, cyc); end
    n_cmp++; if (lvl_bad !== 0) begin n_err++; $display("FAIL rand_level: got %0d violations want 0", lvl_bad); end
    n_cmp++; if (stab_bad !== 0) begin n_err++; $display("FAIL rand_stable: got %0d changes want 0", stab_bad); end
    for (int i = 0; i < 1000; i++) begin
      n_cmp++;
      if (outq[base+i] !== src[sb+i]) begin
        n_err++; ord_bad++;
        if (ord_bad <= 5) $display("FAIL rand_order[%0d]: got %h want %h", i, outq[base+i], src[sb+i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
